// File: rtl/term_tx_sched.sv
// Two-source UART byte scheduler: echo bytes win over refresh bytes, with refresh
// forced through after BURST_MAX echoes in a row. Optional macro TERM_TX_SCHED_STATS_EN adds tx_count.
module term_tx_sched #(
   parameter int BURST_MAX = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] echo_data,
   input  logic       echo_v,
   output logic       echo_rdy,
   input  logic [7:0] rfsh_data,
   input  logic       rfsh_v,
   output logic       rfsh_rdy,
   output logic [7:0] tx_data,
   output logic       tx_v,
   input  logic       tx_rdy
`ifdef TERM_TX_SCHED_STATS_EN
   ,
   output logic [15:0] tx_count
`endif
);

   typedef enum logic {IDLE, GUARD} state_t;

   localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_echo_run;
   logic [3:0] w_run_nxt;
   logic       w_grant;
   logic       w_echo_win;
   logic       w_rfsh_win;
   logic       r_tx_v;
   logic       r_echo_rdy;
   logic       r_rfsh_rdy;
   logic [7:0] r_tx_data;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   // NOTE: each combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_grant) w_state_nxt = GUARD;
         GUARD:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Grant decision and burst-counter update; GUARD ignores every request.
   always_comb begin
      w_grant    = (r_state == IDLE) && tx_rdy && (echo_v || rfsh_v);
      w_echo_win = w_grant && echo_v && !(rfsh_v && (r_echo_run >= BURST_LIM));
      w_rfsh_win = w_grant && !w_echo_win;
      w_run_nxt  = r_echo_run;
      if (w_rfsh_win) begin
         w_run_nxt = 4'd0;
      end else if (w_echo_win) begin
         if (!rfsh_v)                    w_run_nxt = 4'd0;
         else if (r_echo_run < BURST_LIM) w_run_nxt = r_echo_run + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_tx_v     <= 1'b0;
         r_echo_rdy <= 1'b0;
         r_rfsh_rdy <= 1'b0;
         r_tx_data  <= 8'h00;
         r_echo_run <= 4'd0;
      end else begin
         r_tx_v     <= w_grant;
         r_echo_rdy <= w_echo_win;
         r_rfsh_rdy <= w_rfsh_win;
         r_echo_run <= w_run_nxt;
         if (w_grant) r_tx_data <= w_echo_win ? echo_data : rfsh_data;
      end
   end

   assign tx_v     = r_tx_v;
   assign echo_rdy = r_echo_rdy;
   assign rfsh_rdy = r_rfsh_rdy;
   assign tx_data  = r_tx_data;

`ifdef TERM_TX_SCHED_STATS_EN
   logic [15:0] r_tx_count;

   // Counts with the grant so the new value lands on the same edge as tx_v.
   always_ff @(posedge clk) begin
      if (!rst)         r_tx_count <= 16'h0000;
      else if (w_grant) r_tx_count <= r_tx_count + 16'h0001;
   end

   assign tx_count = r_tx_count;
`endif

endmodule

// File: tb/tb_term_tx_sched.sv
// Self-checking bench for term_tx_sched: constant vector table, directed corner
// sequences and a randomized run against a transaction-level reference model.
module tb_term_tx_sched;

   localparam int BM = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] echo_data = 8'h00;
   logic       echo_v = 1'b0;
   logic       echo_rdy;
   logic [7:0] rfsh_data = 8'h00;
   logic       rfsh_v = 1'b0;
   logic       rfsh_rdy;
   logic [7:0] tx_data;
   logic       tx_v;
   logic       tx_rdy = 1'b0;
`ifdef TERM_TX_SCHED_STATS_EN
   logic [15:0] tx_count;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model state: whether the last cycle sent a byte, burst length, last byte, transfer count.
   bit       m_busy = 0;
   int       m_run  = 0;
   bit       e_tx_v, e_echo_rdy, e_rfsh_rdy;
   bit [7:0] e_data = 8'h00;
   int       m_count = 0;

   term_tx_sched #(.BURST_MAX(BM)) dut (
      .clk(clk), .rst(rst),
      .echo_data(echo_data), .echo_v(echo_v), .echo_rdy(echo_rdy),
      .rfsh_data(rfsh_data), .rfsh_v(rfsh_v), .rfsh_rdy(rfsh_rdy),
      .tx_data(tx_data), .tx_v(tx_v), .tx_rdy(tx_rdy)
`ifdef TERM_TX_SCHED_STATS_EN
      , .tx_count(tx_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   // A transfer is one byte leaving per accepted request, then a mandatory idle cycle.
   task automatic model_edge();
      bit take_rfsh;
      e_tx_v = 0; e_echo_rdy = 0; e_rfsh_rdy = 0;
      if (!rst) begin
         m_busy = 0; m_run = 0; e_data = 8'h00; m_count = 0;
      end else if (m_busy) begin
         m_busy = 0;
      end else if (tx_rdy && (echo_v || rfsh_v)) begin
         take_rfsh = rfsh_v && (!echo_v || m_run >= BM);
         if (take_rfsh) begin
            e_data = rfsh_data; e_rfsh_rdy = 1; m_run = 0;
         end else begin
            e_data = echo_data; e_echo_rdy = 1;
            m_run = rfsh_v ? ((m_run + 1 > BM) ? BM : m_run + 1) : 0;
         end
         e_tx_v = 1; m_busy = 1; m_count = (m_count + 1) % 65536;
      end
   endtask

   // Advance one clock and compare all outputs with the model 1 ns after the edge.
   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check("tx_v", {15'd0, tx_v}, {15'd0, e_tx_v});
      check("echo_rdy", {15'd0, echo_rdy}, {15'd0, e_echo_rdy});
      check("rfsh_rdy", {15'd0, rfsh_rdy}, {15'd0, e_rfsh_rdy});
      check("tx_data", {8'd0, tx_data}, {8'd0, e_data});
      if (echo_rdy && rfsh_rdy) check("both_rdy", 16'd1, 16'd0);
`ifdef TERM_TX_SCHED_STATS_EN
      check("tx_count", tx_count, 16'(m_count));
`endif
   endtask

   task automatic drive(input logic r, input logic ev, input logic [7:0] ed,
                        input logic rv, input logic [7:0] rd, input logic tr);
      rst = r; echo_v = ev; echo_data = ed; rfsh_v = rv; rfsh_data = rd; tx_rdy = tr;
   endtask

   typedef struct {
      logic       rst, ev; logic [7:0] ed; logic rv; logic [7:0] rd; logic tr;
      logic       x_tv, x_er, x_rr; logic [7:0] x_d;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int k, n_echo, n_rfsh;
      vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[1] = '{1'b1, 1'b1, 8'h6A, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h6A};
      vecs[2] = '{1'b1, 1'b0, 8'h6A, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h6A};
      vecs[3] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33};
      vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33};
      vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33};
      vecs[6] = '{1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33};
      vecs[7] = '{1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 8'h11};
      vecs[8] = '{1'b1, 1'b0, 8'h11, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11};

      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].rst, vecs[i].ev, vecs[i].ed, vecs[i].rv, vecs[i].rd, vecs[i].tr);
         step();
         check($sformatf("vec%0d_tx_v", i), {15'd0, tx_v}, {15'd0, vecs[i].x_tv});
         check($sformatf("vec%0d_echo_rdy", i), {15'd0, echo_rdy}, {15'd0, vecs[i].x_er});
         check($sformatf("vec%0d_rfsh_rdy", i), {15'd0, rfsh_rdy}, {15'd0, vecs[i].x_rr});
         check($sformatf("vec%0d_tx_data", i), {8'd0, tx_data}, {8'd0, vecs[i].x_d});
      end

      // Sustained contention: 8 echoes then one refresh, a byte every other cycle.
      drive(0, 0, 8'h00, 0, 8'h00, 0); step();
      drive(1, 1, 8'hE0, 1, 8'hF0, 1);
      k = 0;
      for (int i = 0; i < 36; i++) begin
         step();
         check("contention_spacing", {15'd0, tx_v}, {15'd0, (i % 2 == 0)});
         if (tx_v) begin
            check("contention_order", {15'd0, rfsh_rdy}, {15'd0, (k % 9 == 8)});
            k++;
         end
      end

      // Backpressure: a pending refresh must wait for tx_rdy.
      drive(0, 0, 8'h00, 0, 8'h00, 0); step();
      drive(1, 0, 8'h00, 1, 8'h5C, 0);
      n_rfsh = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (tx_v || rfsh_rdy) n_rfsh++;
      end
      check("backpressure_quiet", 16'(n_rfsh), 16'd0);
      tx_rdy = 1;
      step();
      check("backpressure_release", {7'd0, tx_v, tx_data}, {7'd0, 1'b1, 8'h5C});

      // Reset during the guard cycle zeroes tx_data and leaves no stray pulse.
      drive(0, 0, 8'h00, 0, 8'h00, 0); step();
      drive(1, 1, 8'hA5, 0, 8'h00, 1); step();
      check("midrst_grant", {7'd0, echo_rdy, tx_data}, {7'd0, 1'b1, 8'hA5});
      drive(0, 0, 8'h00, 0, 8'h00, 1); step();
      check("midrst_data", {7'd0, tx_v, tx_data}, {7'd0, 1'b0, 8'h00});
      drive(1, 0, 8'h00, 0, 8'h00, 1);
      n_rfsh = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (tx_v || echo_rdy || rfsh_rdy) n_rfsh++;
      end
      check("midrst_no_stray", 16'(n_rfsh), 16'd0);

      // Echo-only stream of 20 bytes keeps the burst count at zero.
      n_echo = 0; n_rfsh = 0;
      drive(1, 1, 8'h40, 0, 8'h00, 1);
      for (int i = 0; i < 40; i++) begin
         step();
         if (echo_rdy) begin n_echo++; echo_data = echo_data + 8'h01; end
         if (rfsh_rdy) n_rfsh++;
      end
      check("echo_only_count", 16'(n_echo), 16'd20);
      check("echo_only_no_rfsh", 16'(n_rfsh), 16'd0);
      rfsh_v = 1; rfsh_data = 8'h99;
      k = 0;
      for (int i = 0; i < 18; i++) begin
         step();
         if (tx_v) begin
            check("post_echo_burst", {15'd0, rfsh_rdy}, {15'd0, (k == 8)});
            k++;
         end
      end
      check("post_echo_grants", 16'(k), 16'd9);

      // Randomized traffic, including protocol violations and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 49) != 0), $urandom_range(0, 1), 8'($urandom),
               ($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 4) != 0));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
